// File: rtl/exec_mc_scheduler_if.sv
// exec_mc_scheduler_if: issue/unit/result bundle between the execute stage,
// the multi-cycle unit wrappers and exec_mc_scheduler.
// master = execute stage plus unit wrappers, slave = the scheduler itself.
interface exec_mc_scheduler_if #(
  parameter int XLEN = 32
);
  // Issue side
  logic            issue_valid;
  logic [1:0]      issue_unit;
  logic            issue_ready;
  logic            clear;
  // Unit start pulses
  logic            div_enable;
  logic            clmul_enable;
  logic            fpu_enable;
  // Unit completion
  logic            div_ready;
  logic            clmul_ready;
  logic            fpu_ready;
  logic [XLEN-1:0] div_result;
  logic [XLEN-1:0] clmul_result;
  logic [XLEN-1:0] fpu_result;
  logic [4:0]      fpu_flags;
  // Execute-stage outputs
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      flags;
  logic            timeout_err;
  logic [31:0]     perf_busy;
  logic [31:0]     perf_ops;

  modport master (
    output issue_valid, issue_unit, clear,
    output div_ready, clmul_ready, fpu_ready,
    output div_result, clmul_result, fpu_result, fpu_flags,
    input  issue_ready, div_enable, clmul_enable, fpu_enable,
    input  stall, done, result, flags, timeout_err, perf_busy, perf_ops
  );

  modport slave (
    input  issue_valid, issue_unit, clear,
    input  div_ready, clmul_ready, fpu_ready,
    input  div_result, clmul_result, fpu_result, fpu_flags,
    output issue_ready, div_enable, clmul_enable, fpu_enable,
    output stall, done, result, flags, timeout_err, perf_busy, perf_ops
  );
endinterface

// File: rtl/exec_mc_scheduler.sv
// exec_mc_scheduler: sequences the iterative divider, carry-less multiplier
// and FPU behind a single issue port. One operation in flight at a time; the
// selected unit gets a one-cycle enable, the execute stage is stalled while
// the unit works, and the result comes back with a one-cycle done pulse.
// A pipeline clear drains the killed unit; a watchdog aborts hung units.
// Optional performance counters are built when MC_SCHED_PERF_EN is defined.
module exec_mc_scheduler #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  exec_mc_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0]       UNIT_DIV   = 2'd0;
  localparam logic [1:0]       UNIT_CLMUL = 2'd1;
  localparam logic [1:0]       UNIT_FPU   = 2'd2;
  localparam logic [1:0]       UNIT_ILL   = 2'd3;
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [1:0]        unit_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              div_en_q;
  logic              clmul_en_q;
  logic              fpu_en_q;
  logic              stall_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        flags_q;
  logic              timeout_q;

  logic              sel_ready_c;
  logic [XLEN-1:0]   sel_result_c;
  logic [4:0]        sel_flags_c;
  logic              wd_hit_c;
  logic              issue_take_c;

  // Route the latched unit's completion signals; other units are ignored.
  always_comb begin
    sel_ready_c  = 1'b0;
    sel_result_c = '0;
    sel_flags_c  = '0;
    unique case (unit_q)
      UNIT_DIV: begin
        sel_ready_c  = bus.div_ready;
        sel_result_c = bus.div_result;
      end
      UNIT_CLMUL: begin
        sel_ready_c  = bus.clmul_ready;
        sel_result_c = bus.clmul_result;
      end
      default: begin
        sel_ready_c  = bus.fpu_ready;
        sel_result_c = bus.fpu_result;
        sel_flags_c  = bus.fpu_flags;
      end
    endcase
    // Compare with >= so a clear landing on the last watchdog cycle still
    // lets DRAIN exit on the very next cycle.
    wd_hit_c     = (cnt_q >= WD_LAST);
    issue_take_c = (state_q == IDLE) && bus.issue_valid && !bus.clear;
  end

  // Scheduler FSM with registered enables, stall, done, result and flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      unit_q     <= UNIT_DIV;
      cnt_q      <= '0;
      div_en_q   <= 1'b0;
      clmul_en_q <= 1'b0;
      fpu_en_q   <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      div_en_q   <= 1'b0;
      clmul_en_q <= 1'b0;
      fpu_en_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (issue_take_c) begin
            if (bus.issue_unit == UNIT_ILL) begin
              // Illegal unit completes immediately with a zero result.
              done_q   <= 1'b1;
              result_q <= '0;
              flags_q  <= '0;
            end else begin
              unit_q     <= bus.issue_unit;
              state_q    <= BUSY;
              stall_q    <= 1'b1;
              cnt_q      <= '0;
              div_en_q   <= (bus.issue_unit == UNIT_DIV);
              clmul_en_q <= (bus.issue_unit == UNIT_CLMUL);
              fpu_en_q   <= (bus.issue_unit == UNIT_FPU);
            end
          end
        end
        BUSY: begin
          if (bus.clear) begin
            // Killed op: drop the stall now, wait out the unit if needed.
            stall_q <= 1'b0;
            if (sel_ready_c) begin
              state_q <= IDLE;
            end else begin
              state_q <= DRAIN;
              cnt_q   <= cnt_q + 1'b1;
            end
          end else if (sel_ready_c) begin
            state_q  <= IDLE;
            stall_q  <= 1'b0;
            done_q   <= 1'b1;
            result_q <= sel_result_c;
            flags_q  <= sel_flags_c;
          end else if (wd_hit_c) begin
            state_q   <= IDLE;
            stall_q   <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            result_q  <= '0;
            flags_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          // The drained result is discarded; the watchdog exits silently.
          if (sel_ready_c || wd_hit_c) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.issue_ready  = (state_q == IDLE);
  assign bus.div_enable   = div_en_q;
  assign bus.clmul_enable = clmul_en_q;
  assign bus.fpu_enable   = fpu_en_q;
  assign bus.stall        = stall_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.flags        = flags_q;
  assign bus.timeout_err  = timeout_q;

`ifdef MC_SCHED_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_ops_q;
  logic        fin_c;

  // Same conditions that raise done on the next edge.
  always_comb begin
    fin_c = 1'b0;
    if (issue_take_c && (bus.issue_unit == UNIT_ILL)) begin
      fin_c = 1'b1;
    end
    if ((state_q == BUSY) && !bus.clear && (sel_ready_c || wd_hit_c)) begin
      fin_c = 1'b1;
    end
  end

  // Free-running busy-cycle and completed-op counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_busy_q <= '0;
      perf_ops_q  <= '0;
    end else begin
      if ((state_q == BUSY) || (state_q == DRAIN)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (fin_c) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
    end
  end

  assign bus.perf_busy = perf_busy_q;
  assign bus.perf_ops  = perf_ops_q;
`else
  assign bus.perf_busy = 32'd0;
  assign bus.perf_ops  = 32'd0;
`endif

endmodule

// File: tb/tb_exec_mc_scheduler.sv
// tb_exec_mc_scheduler: directed and randomized checks of exec_mc_scheduler
// with TIMEOUT=8. Each operation's expected cycle-by-cycle behaviour is
// derived from its ready/clear timing at the transaction level.
// Perf expectations follow MC_SCHED_PERF_EN.
module tb_exec_mc_scheduler;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pbusy = 0;
  int exp_pops  = 0;

  exec_mc_scheduler_if #(.XLEN(XLEN)) bus ();

  exec_mc_scheduler #(.XLEN(XLEN), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_perf();
`ifdef MC_SCHED_PERF_EN
    chk("perf_busy", bus.perf_busy, 32'(exp_pbusy));
    chk("perf_ops",  bus.perf_ops,  32'(exp_pops));
`else
    chk("perf_busy", bus.perf_busy, 32'd0);
    chk("perf_ops",  bus.perf_ops,  32'd0);
`endif
  endtask

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_unit   = 2'd0;
    bus.clear        = 1'b0;
    bus.div_ready    = 1'b0;
    bus.clmul_ready  = 1'b0;
    bus.fpu_ready    = 1'b0;
    bus.div_result   = '0;
    bus.clmul_result = '0;
    bus.fpu_result   = '0;
    bus.fpu_flags    = '0;
  endtask

  // One operation: unit, ready delay d (in BUSY cycles after enable),
  // clear delay c (-1 = no clear), unit result/flags, stray readies.
  task automatic run_op(input int unit, input int d, input int c,
                        input logic [31:0] rv, input logic [4:0] fv, input bit stray);
    int kb, ke, dm, im, m;
    bit has_done, to;
    logic [31:0] er;
    logic [4:0]  ef;
    logic [2:0]  en_exp;
    kb = 0; ke = 0; has_done = 1'b0; to = 1'b0; er = '0; ef = '0;
    if (unit == 3) begin
      has_done = 1'b1;
    end else if (c >= 0 && c <= d) begin
      kb = c;
      if (c == d)          ke = c;
      else if (d < TO - 1) ke = d;
      else                 ke = TO - 1;
    end else if (d <= TO - 1) begin
      kb = d; ke = d; has_done = 1'b1; er = rv;
      ef = (unit == 2) ? fv : 5'd0;
    end else begin
      kb = TO - 1; ke = TO - 1; has_done = 1'b1; to = 1'b1;
    end
    dm = (unit == 3) ? 1 : 2 + kb;
    im = (unit == 3) ? 1 : 2 + ke;

    for (int j = 0; j < im; j++) begin
      bus.issue_valid  = (j == 0);
      bus.issue_unit   = (j == 0) ? 2'(unit) : 2'($urandom_range(0, 3));
      bus.clear        = (c >= 0) && (j == 1 + c);
      bus.div_ready    = (unit == 0) ? (j == 1 + d) : (stray && $urandom_range(0, 1) == 1);
      bus.clmul_ready  = (unit == 1) ? (j == 1 + d) : (stray && $urandom_range(0, 1) == 1);
      bus.fpu_ready    = (unit == 2) ? (j == 1 + d) : (stray && $urandom_range(0, 1) == 1);
      bus.div_result   = (unit == 0) ? rv : $urandom;
      bus.clmul_result = (unit == 1) ? rv : $urandom;
      bus.fpu_result   = (unit == 2) ? rv : $urandom;
      bus.fpu_flags    = (unit == 2) ? fv : 5'($urandom_range(0, 31));
      tick();
      m = j + 1;
      en_exp = (m == 1 && unit != 3) ? 3'(1 << unit) : 3'd0;
      chk("enables", 32'({bus.fpu_enable, bus.clmul_enable, bus.div_enable}), 32'(en_exp));
      chk("stall", 32'(bus.stall), 32'(unit != 3 && m <= 1 + kb));
      chk("done", 32'(bus.done), 32'(has_done && m == dm));
      chk("timeout_err", 32'(bus.timeout_err), 32'(to && m == dm));
      chk("issue_ready", 32'(bus.issue_ready), 32'(m >= im));
      if (has_done && m == dm) begin
        chk("result", bus.result, er);
        chk("flags", 32'(bus.flags), 32'(ef));
      end
    end
    if (unit != 3) exp_pbusy += ke + 1;
    if (has_done)  exp_pops++;
    check_perf();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick(); tick(); tick();
    // Reset state
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rst_enables", 32'({bus.fpu_enable, bus.clmul_enable, bus.div_enable}), 32'd0);
    check_perf();
    reset = 1'b1;

    // Watchdog first, so perf counters read exactly 8 busy / 1 op
    run_op(2, 100, -1, 32'hDEAD_BEEF, 5'd3, 1'b0);
`ifdef MC_SCHED_PERF_EN
    chk("wd_perf_busy_abs", bus.perf_busy, 32'd8);
    chk("wd_perf_ops_abs", bus.perf_ops, 32'd1);
`endif

    // Issue together with clear is ignored
    bus.issue_valid = 1'b1; bus.issue_unit = 2'd0; bus.clear = 1'b1;
    tick();
    chk("clr_issue_enables", 32'({bus.fpu_enable, bus.clmul_enable, bus.div_enable}), 32'd0);
    chk("clr_issue_stall", 32'(bus.stall), 32'd0);
    chk("clr_issue_ready", 32'(bus.issue_ready), 32'd1);
    bus.issue_unit = 2'd3;
    tick();
    chk("clr_illegal_done", 32'(bus.done), 32'd0);
    idle_inputs();

    // Div normal: ready at T0+5, result 7
    run_op(0, 4, -1, 32'h0000_0007, 5'd0, 1'b0);
    // FPU flags with clmul_ready noise
    run_op(2, 2, -1, 32'h3F80_0000, 5'b00001, 1'b1);
    // Clear at 2nd BUSY cycle, div ready 4 cycles later
    run_op(0, 5, 1, 32'h1234_5678, 5'd0, 1'b0);
    // Clear and ready coincide
    run_op(1, 3, 3, 32'hCAFE_F00D, 5'd0, 1'b0);
    // Illegal unit
    run_op(3, 0, -1, 32'h0, 5'd0, 1'b1);
    // Ready combinational to enable: done at T+2
    run_op(1, 0, -1, 32'hA5A5_5A5A, 5'd0, 1'b1);
    // Ready on the last watchdog cycle wins over the abort
    run_op(2, TO - 1, -1, 32'h0BAD_CAFE, 5'd16, 1'b1);
    // Drain that outlives the watchdog exits silently
    run_op(0, 20, 0, 32'h1111_2222, 5'd0, 1'b1);

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      int u, d, c;
      u = $urandom_range(0, 3);
      d = $urandom_range(0, 11);
      c = ($urandom_range(0, 2) == 0) ? $urandom_range(0, TO - 2) : -1;
      run_op(u, d, c, $urandom, 5'($urandom_range(0, 31)), 1'b1);
    end

    // Reset during BUSY
    idle_inputs();
    bus.issue_valid = 1'b1; bus.issue_unit = 2'd0;
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    reset = 1'b0;
    tick();
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_flags", 32'(bus.flags), 32'd0);
    chk("midrst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("midrst_enables", 32'({bus.fpu_enable, bus.clmul_enable, bus.div_enable}), 32'd0);
    chk("midrst_issue_ready", 32'(bus.issue_ready), 32'd1);
    exp_pbusy = 0;
    exp_pops  = 0;
    check_perf();
    reset = 1'b1;
    bus.div_ready  = 1'b1;
    bus.div_result = 32'h5555_AAAA;
    tick();
    chk("postrst_done", 32'(bus.done), 32'd0);
    chk("postrst_issue_ready", 32'(bus.issue_ready), 32'd1);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_mc_scheduler.md
Name: exec_mc_scheduler

Overview:
- Sequences the multi-cycle execute-stage units (iterative divider, carry-less multiplier, FPU) behind one issue interface.
- Accepts one operation at a time and fires a single-cycle enable to the selected unit. Generates the execute stall while the unit is busy and returns the unit's result with a done pulse.
- Handles pipeline clear mid-operation by draining the killed unit. A watchdog aborts hung units.
- Sits between execute-stage decode of division/bitc/fpu and the unit wrappers; replaces per-unit enable/ready glue.

Parameters:
- XLEN, 32, datapath width of operands/results
- TIMEOUT, 64, max BUSY cycles before watchdog abort (must be >= 2)
- CNT_W, 7, width of watchdog counter (must hold TIMEOUT)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- issue_valid  in  1  operation request this cycle
- issue_unit  in  2  0=div, 1=clmul, 2=fpu, 3=illegal
- issue_ready  out  1  scheduler can accept (state IDLE)
- clear  in  1  pipeline kill (trap/mret/flush)
- div_enable / clmul_enable / fpu_enable  out  1 each  one-cycle start pulse to unit
- div_ready / clmul_ready / fpu_ready  in  1 each  unit result valid
- div_result / clmul_result / fpu_result  in  XLEN each  unit results
- fpu_flags  in  5  FPU exception flags
- stall  out  1  execute stall request
- done  out  1  one-cycle completion pulse
- result  out  XLEN  captured result, valid with done
- flags  out  5  captured flags (0 for non-FPU), valid with done
- timeout_err  out  1  one-cycle pulse with done on watchdog abort
- perf_busy  out  32  busy-cycle count (feature-gated)
- perf_ops  out  32  completed-op count (feature-gated)

Behaviour:
- All outputs registered except issue_ready (= state==IDLE).
- Reset values: state IDLE, all enables 0, stall 0, done 0, result 0, flags 0, timeout_err 0, counter 0, perf counters 0.
- Reset mid-operation: state returns to IDLE. No enable or done is generated for the in-flight op.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - issue_valid=1, clear=0, unit 0..2: latch unit. Next cycle state=BUSY, matching enable=1 for exactly one cycle, stall=1, counter=0.
  - issue_valid=1 with clear=1: ignored.
  - issue_unit=3: no enable. Next cycle done=1, result=0, flags=0, stays IDLE.
- BUSY:
  - stall=1; counter increments each cycle. Only the latched unit's ready is observed; other readies are ignored.
  - Ready sampled 1 with clear=0: next cycle done=1, result/flags captured (flags=fpu_flags only for fpu), stall=0, state=IDLE.
  - clear=1 and ready=1 same cycle: result discarded, no done, stall=0, state=IDLE.
  - clear=1, ready=0: state=DRAIN, stall=0, no done.
  - counter==TIMEOUT-1 and ready=0, clear=0: next cycle done=1, timeout_err=1, result=0, flags=0, stall=0, state=IDLE.
- DRAIN:
  - issue_ready=0, stall=0. Wait for latched unit's ready, which is discarded. Then state=IDLE.
  - Watchdog also applies here: at TIMEOUT-1, go IDLE silently (no done).
- Latency: issue accepted at cycle T, enable at T+1. Done is 1 cycle after the ready sample. Minimum T+2 with a ready that is combinational to the enable.
- done and timeout_err are never asserted in consecutive cycles for one operation. Back-to-back issue is allowed the cycle done is high (state is IDLE).

Optional Feature:
- Macro MC_SCHED_PERF_EN.
- Defined:
  - perf_busy increments every cycle state is BUSY or DRAIN; wraps at 2^32.
  - perf_ops increments on every done pulse, including illegal and timeout completions; wraps.
- Undefined: both ports driven constant 0; no counter flops synthesized.

Test Plan:
- Div normal: issue unit=0 at T0; div_ready=1 at T0+5 with div_result=0x0000_0007 -> div_enable only at T0+1, stall 1 during T0+1..T0+5, done=1/result=0x7 at T0+6, stall=0.
- FPU flags: issue unit=2; fpu_ready at 3rd BUSY cycle with fpu_result=0x3F80_0000, fpu_flags=5'b00001 -> done with result 0x3F80_0000, flags 0x01; clmul_ready pulses during BUSY are ignored.
- Clear mid-op: issue unit=0; clear at 2nd BUSY cycle; div_ready 4 cycles later -> no done, stall 0 from the cycle after clear, issue_ready 0 until the cycle after div_ready, then 1.
- Clear and ready coincide: unit=1, clmul_ready=1 and clear=1 same cycle -> no done, next state IDLE, issue_ready=1.
- Watchdog with TIMEOUT=8: issue unit=2, fpu_ready never set -> done=1, timeout_err=1, result=0 exactly 8 BUSY cycles after entry; perf_ops=1, perf_busy=8 when MC_SCHED_PERF_EN is defined, both 0 otherwise.
- Illegal and reset: issue unit=3 -> no enables, done=1, result=0 next cycle. Reset=0 asserted during BUSY -> all outputs 0 next cycle, issue_ready=1.
